// File: rtl/alu_ctrl_pkg.sv
// Shared opcode map and sequencer state encoding for the ALU access controller.
package alu_ctrl_pkg;

    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_REM    = 3'd2;
    localparam logic [2:0] OP_AND    = 3'd3;
    localparam logic [2:0] OP_OR     = 3'd4;
    localparam logic [2:0] OP_CONCAT = 3'd5;
    localparam logic [2:0] OP_EQUAL  = 3'd6;
    localparam logic [2:0] OP_LESS   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to the pointer.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o,
    output logic       idx_o
);

    always_comb begin
        gnt_o = 2'b00;
        idx_o = 1'b0;
        case (req_i)
            2'b01: begin
                gnt_o = 2'b01;
                idx_o = 1'b0;
            end
            2'b10: begin
                gnt_o = 2'b10;
                idx_o = 1'b1;
            end
            2'b11: begin
                gnt_o = ptr_i ? 2'b10 : 2'b01;
                idx_o = ptr_i;
            end
            default: begin
                gnt_o = 2'b00;
                idx_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_access_ctrl.sv
// Shares one external combinational ALU between two requesters: accept, execute, return.
module alu_access_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int W          = 8,
    parameter int NREQ       = 2,
    parameter int DIV0_CHECK = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_x,
    input  logic [NREQ*W-1:0]   req_y,
    input  logic [NREQ*3-1:0]   req_op,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [W-1:0]        rsp_z,
    output logic                rsp_cout,
    output logic                rsp_ov,
    output logic                rsp_zf,
    output logic                rsp_err,
    output logic [W-1:0]        alu_x,
    output logic [W-1:0]        alu_y,
    output logic [2:0]          alu_c,
    input  logic [W-1:0]        alu_z,
    input  logic                alu_cout,
    input  logic                alu_ov,
    input  logic                alu_zf
);

    state_e         state_q, state_d;
    logic           ptr_q, ptr_d;
    logic           gnt_q, gnt_d;
    logic [W-1:0]   alu_x_q, alu_x_d;
    logic [W-1:0]   alu_y_q, alu_y_d;
    logic [2:0]     alu_c_q, alu_c_d;
    logic [W-1:0]   rsp_z_q, rsp_z_d;
    logic           rsp_cout_q, rsp_cout_d;
    logic           rsp_ov_q, rsp_ov_d;
    logic           rsp_zf_q, rsp_zf_d;
    logic           rsp_err_q, rsp_err_d;

    logic [1:0]     arb_gnt;
    logic           arb_idx;
    logic           div0;

    rr_arb2 u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign div0 = (DIV0_CHECK != 0) && (alu_c_q == OP_REM) && (alu_y_q == '0);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        alu_x_d    = alu_x_q;
        alu_y_d    = alu_y_q;
        alu_c_d    = alu_c_q;
        rsp_z_d    = rsp_z_q;
        rsp_cout_d = rsp_cout_q;
        rsp_ov_d   = rsp_ov_q;
        rsp_zf_d   = rsp_zf_q;
        rsp_err_d  = rsp_err_q;
        req_ready  = '0;
        rsp_valid  = '0;
        case (state_q)
            ST_IDLE: begin
                // No accept may be signalled while reset is held, even from IDLE.
                if ((|req_valid) && rst_n) begin
                    req_ready = arb_gnt;
                    gnt_d     = arb_idx;
                    alu_x_d   = arb_idx ? req_x[2*W-1:W] : req_x[W-1:0];
                    alu_y_d   = arb_idx ? req_y[2*W-1:W] : req_y[W-1:0];
                    alu_c_d   = arb_idx ? req_op[5:3]    : req_op[2:0];
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (div0) begin
                    rsp_z_d    = '0;
                    rsp_cout_d = 1'b0;
                    rsp_ov_d   = 1'b0;
                    rsp_zf_d   = 1'b1;
                    rsp_err_d  = 1'b1;
                end else begin
                    rsp_z_d    = alu_z;
                    rsp_cout_d = alu_cout;
                    rsp_ov_d   = alu_ov;
                    rsp_zf_d   = alu_zf;
                    rsp_err_d  = 1'b0;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) begin
                    ptr_d   = ~gnt_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            gnt_q      <= 1'b0;
            alu_x_q    <= '0;
            alu_y_q    <= '0;
            alu_c_q    <= '0;
            rsp_z_q    <= '0;
            rsp_cout_q <= 1'b0;
            rsp_ov_q   <= 1'b0;
            rsp_zf_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            alu_x_q    <= alu_x_d;
            alu_y_q    <= alu_y_d;
            alu_c_q    <= alu_c_d;
            rsp_z_q    <= rsp_z_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_ov_q   <= rsp_ov_d;
            rsp_zf_q   <= rsp_zf_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign alu_x    = alu_x_q;
    assign alu_y    = alu_y_q;
    assign alu_c    = alu_c_q;
    assign rsp_z    = rsp_z_q;
    assign rsp_cout = rsp_cout_q;
    assign rsp_ov   = rsp_ov_q;
    assign rsp_zf   = rsp_zf_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_alu_access_ctrl.sv
// Directed bench for alu_access_ctrl with a behavioural 8-bit ALU attached to its alu_* ports.
module tb_alu_access_ctrl;
    import alu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [15:0] req_x, req_y;
    logic [5:0]  req_op;
    logic [7:0]  rsp_z, alu_x, alu_y, alu_z;
    logic        rsp_cout, rsp_ov, rsp_zf, rsp_err;
    logic [2:0]  alu_c;
    logic        alu_cout, alu_ov, alu_zf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_z(rsp_z), .rsp_cout(rsp_cout), .rsp_ov(rsp_ov), .rsp_zf(rsp_zf), .rsp_err(rsp_err),
        .alu_x(alu_x), .alu_y(alu_y), .alu_c(alu_c),
        .alu_z(alu_z), .alu_cout(alu_cout), .alu_ov(alu_ov), .alu_zf(alu_zf)
    );

    always_comb begin
        logic [8:0] t;
        t        = 9'd0;
        alu_cout = 1'b0;
        alu_ov   = 1'b0;
        case (alu_c)
            OP_ADD: begin
                t = {1'b0, alu_x} + {1'b0, alu_y};
                alu_ov = (alu_x[7] == alu_y[7]) && (t[7] != alu_x[7]);
            end
            OP_SUB: begin
                t = {1'b0, alu_x} - {1'b0, alu_y};
                alu_ov = (alu_x[7] != alu_y[7]) && (t[7] != alu_x[7]);
            end
            OP_REM:    t = (alu_y == 8'd0) ? 9'd0 : {1'b0, alu_x % alu_y};
            OP_AND:    t = {1'b0, alu_x & alu_y};
            OP_OR:     t = {1'b0, alu_x | alu_y};
            OP_CONCAT: t = {1'b0, alu_x[3:0], alu_y[3:0]};
            OP_EQUAL:  t = {8'd0, alu_x == alu_y};
            default:   t = {8'd0, alu_x < alu_y};
        endcase
        alu_z    = t[7:0];
        alu_cout = t[8];
        alu_zf   = (t[7:0] == 8'd0);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
        req_x = '0; req_y = '0; req_op = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one op for requester r; lat = cycles from accept to rsp_valid, -1 on timeout.
    task automatic issue(input int r, input logic [7:0] x, input logic [7:0] y, input logic [2:0] op,
                         output int lat, output logic [7:0] z, output logic [3:0] fl);
        int n;
        lat = -1; z = 8'hxx; fl = 4'hx;
        @(negedge clk);
        req_x[r*8 +: 8] = x; req_y[r*8 +: 8] = y; req_op[r*3 +: 3] = op;
        req_valid[r] = 1'b1; rsp_ready = '0;
        #1;
        n = 0;
        while (!req_ready[r] && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready[r]) begin
            req_valid[r] = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[r] = 1'b0;
        #1;
        n = 1;
        while (!rsp_valid[r] && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!rsp_valid[r]) return;
        lat = n; z = rsp_z; fl = {rsp_cout, rsp_ov, rsp_zf, rsp_err};
        rsp_ready[r] = 1'b1;
        @(negedge clk);
        rsp_ready[r] = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({req_ready, rsp_valid} !== 4'b0 || {alu_x, alu_y, alu_c} !== 19'd0 ||
            {rsp_z, rsp_cout, rsp_ov, rsp_zf, rsp_err} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b x=%h y=%h c=%h z=%h flags=%b, want all 0",
                     req_ready, rsp_valid, alu_x, alu_y, alu_c, rsp_z, {rsp_cout, rsp_ov, rsp_zf, rsp_err});
        end
        $display("reset: outputs after reset checked");
    endtask

    task automatic test_add();
        @(negedge clk);
        req_x = 16'h007F; req_y = 16'h0001; req_op = {3'd0, OP_ADD}; req_valid = 2'b01; #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL add_accept: req_ready=%b want 01", req_ready); end
        @(negedge clk); req_valid = 2'b00; #1;
        checks++;
        if (rsp_valid !== 2'b00 || alu_x !== 8'h7F || alu_y !== 8'h01 || alu_c !== OP_ADD) begin
            errors++;
            $display("FAIL add_exec: vld=%b x=%h y=%h c=%0d want 00 7f 01 0", rsp_valid, alu_x, alu_y, alu_c);
        end
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_z !== 8'h80 || {rsp_cout, rsp_ov, rsp_zf, rsp_err} !== 4'b0100) begin
            errors++;
            $display("FAIL add_result: vld=%b z=%h cout/ov/zf/err=%b want 01 80 0100",
                     rsp_valid, rsp_z, {rsp_cout, rsp_ov, rsp_zf, rsp_err});
        end
        rsp_ready = 2'b01;
        @(negedge clk); rsp_ready = 2'b00; #1;
        checks++;
        if (rsp_valid !== 2'b00) begin errors++; $display("FAIL add_release: rsp_valid=%b want 00", rsp_valid); end
        $display("add: 7f+01 -> z=%h", rsp_z);
    endtask

    task automatic test_both_valid();
        do_reset();
        @(negedge clk);
        req_x = 16'hF005; req_y = 16'h0F05; req_op = {OP_AND, OP_SUB}; req_valid = 2'b11; #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL both_first_grant: req_ready=%b want 01", req_ready); end
        @(negedge clk); req_valid = 2'b10; #1;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_z !== 8'h00 || rsp_zf !== 1'b1 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL both_req0_result: vld=%b z=%h zf=%b err=%b want 01 00 1 0", rsp_valid, rsp_z, rsp_zf, rsp_err);
        end
        rsp_ready = 2'b11;
        @(negedge clk); rsp_ready = 2'b00; #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL both_second_grant: req_ready=%b want 10", req_ready); end
        @(negedge clk); req_valid = 2'b00; #1;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b10 || rsp_z !== 8'h00 || rsp_zf !== 1'b1 || alu_c !== OP_AND) begin
            errors++;
            $display("FAIL both_req1_result: vld=%b z=%h zf=%b c=%0d want 10 00 1 3", rsp_valid, rsp_z, rsp_zf, alu_c);
        end
        rsp_ready = 2'b10;
        @(negedge clk); rsp_ready = 2'b00;
        $display("both_valid: req0 sub then req1 and served");
    endtask

    task automatic test_div0();
        int lat; logic [7:0] z; logic [3:0] fl;
        issue(1, 8'h09, 8'h00, OP_REM, lat, z, fl);
        checks++;
        if (lat !== 2 || z !== 8'h00 || fl !== 4'b0011) begin
            errors++;
            $display("FAIL div0_trap: lat=%0d z=%h cout/ov/zf/err=%b want 2 00 0011", lat, z, fl);
        end
        $display("div0: 09 rem 00 -> z=%h flags=%b", z, fl);
        issue(1, 8'h09, 8'h04, OP_REM, lat, z, fl);
        checks++;
        if (lat !== 2 || z !== 8'h01 || fl !== 4'b0000) begin
            errors++;
            $display("FAIL rem_normal: lat=%0d z=%h cout/ov/zf/err=%b want 2 01 0000", lat, z, fl);
        end
        $display("rem: 09 rem 04 -> z=%h flags=%b", z, fl);
        issue(0, 8'h20, 8'h05, OP_LESS, lat, z, fl);
        checks++;
        if (lat !== 2 || z !== 8'h00 || fl !== 4'b0010) begin
            errors++;
            $display("FAIL less_false: lat=%0d z=%h flags=%b want 2 00 0010", lat, z, fl);
        end
        issue(0, 8'hA5, 8'h3C, OP_CONCAT, lat, z, fl);
        checks++;
        if (lat !== 2 || z !== 8'h5C || fl !== 4'b0000) begin
            errors++;
            $display("FAIL concat: lat=%0d z=%h flags=%b want 2 5c 0000", lat, z, fl);
        end
        issue(1, 8'h00, 8'h01, OP_SUB, lat, z, fl);
        checks++;
        if (lat !== 2 || z !== 8'hFF || fl !== 4'b1000) begin
            errors++;
            $display("FAIL sub_borrow: lat=%0d z=%h flags=%b want 2 ff 1000", lat, z, fl);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        req_x = 16'hFF12; req_y = 16'h3C21; req_op = {OP_AND, OP_OR}; req_valid = 2'b01; #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_accept0: req_ready=%b want 01", req_ready); end
        @(negedge clk); req_valid = 2'b10; #1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rsp_valid !== 2'b01 || rsp_z !== 8'h33 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold[%0d]: vld=%b z=%h rdy=%b want 01 33 00", i, rsp_valid, rsp_z, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 2'b01; #1;
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_no_early_accept: req_ready=%b want 00", req_ready); end
        @(negedge clk); rsp_ready = 2'b00; #1;
        checks++;
        if (req_ready !== 2'b10 || rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL bp_accept1: rdy=%b vld=%b want 10 00", req_ready, rsp_valid);
        end
        @(negedge clk); req_valid = 2'b00;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b10 || rsp_z !== 8'h3C) begin
            errors++;
            $display("FAIL bp_result1: vld=%b z=%h want 10 3c", rsp_valid, rsp_z);
        end
        rsp_ready = 2'b10;
        @(negedge clk); rsp_ready = 2'b00;
        $display("backpressure: held 5 cycles, req1 accepted after handshake");
    endtask

    task automatic test_reset_in_flight();
        @(negedge clk);
        req_x = 16'h0001; req_y = 16'h0001; req_op = {3'd0, OP_ADD}; req_valid = 2'b01; #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL rif_accept: req_ready=%b want 01", req_ready); end
        @(negedge clk); req_valid = 2'b00; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; #1;
        checks++;
        if ({req_ready, rsp_valid} !== 4'b0 || {alu_x, alu_y, alu_c} !== 19'd0 ||
            {rsp_z, rsp_cout, rsp_ov, rsp_zf, rsp_err} !== 12'd0) begin
            errors++;
            $display("FAIL rif_cleared: rdy=%b vld=%b x=%h y=%h c=%h z=%h, want all 0",
                     req_ready, rsp_valid, alu_x, alu_y, alu_c, rsp_z);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++;
            if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rif_no_rsp[%0d]: rsp_valid=%b want 00", i, rsp_valid); end
        end
        $display("reset_in_flight: op dropped");
    endtask

    task automatic test_back_to_back();
        int ng, cyc;
        int gseq[6];
        int gcyc[6];
        do_reset();
        @(negedge clk);
        req_x = 16'h4010; req_y = 16'h0201; req_op = {OP_OR, OP_ADD};
        rsp_ready = 2'b11; req_valid = 2'b11;
        ng = 0; cyc = 0;
        while (ng < 6 && cyc < 60) begin
            #1;
            if (rsp_valid != 2'b00) begin
                checks++;
                if (rsp_z !== (rsp_valid[0] ? 8'h11 : 8'h42)) begin
                    errors++;
                    $display("FAIL b2b_z: vld=%b z=%h want %h", rsp_valid, rsp_z, rsp_valid[0] ? 8'h11 : 8'h42);
                end
            end
            if (req_ready != 2'b00) begin
                gseq[ng] = int'(req_ready[1]);
                gcyc[ng] = cyc;
                $display("back_to_back: grant %0d to req%0d at cycle %0d", ng, gseq[ng], cyc);
                ng++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (ng != 6) begin errors++; $display("FAIL b2b_count: grants=%0d want 6", ng); end
        for (int i = 0; i < ng; i++) begin
            checks++;
            if (gseq[i] != i % 2) begin errors++; $display("FAIL b2b_order[%0d]: req%0d want req%0d", i, gseq[i], i % 2); end
            if (i > 0) begin
                checks++;
                if (gcyc[i] - gcyc[i-1] != 3) begin
                    errors++;
                    $display("FAIL b2b_spacing[%0d]: %0d cycles want 3", i, gcyc[i] - gcyc[i-1]);
                end
            end
        end
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
        rsp_ready = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
        req_x = '0; req_y = '0; req_op = '0;
        test_reset();
        test_add();
        test_both_valid();
        test_div0();
        test_backpressure();
        test_reset_in_flight();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
